// File: rtl/new_patch_rd_arbiter.sv
// new_patch_rd_arbiter
// Shares the single read port of the new-patches RAM between the workspace
// readout (requester 0) and the simulation/debug dump path (requester 1).
// Bursts are granted round-robin and are never preempted. The block drives the
// RAM address/enable and returns per-requester valid/last/done tags that line
// up with the RAM output data RD_LAT cycles after each read enable.
// Lives in the div4 clock domain.

module new_patch_rd_arbiter #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] start0,
    input  logic [LEN_W-1:0]  len0,
    output logic              gnt0,
    output logic              valid0,
    output logic              last0,
    output logic              done0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] start1,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt1,
    output logic              valid1,
    output logic              last1,
    output logic              done1,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t              state_q;
    state_t              state_d;
    logic                rr_q;          // requester that has priority next
    logic                rr_d;
    logic                owner_q;       // requester owning the current burst
    logic                owner_d;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [ADDR_W-1:0]   cur_addr_d;
    logic [LEN_W-1:0]    remaining_q;
    logic [LEN_W-1:0]    remaining_d;

    // Valid pipeline: one {valid, owner, last} entry per RAM latency stage
    logic [RD_LAT-1:0]   pipe_vld_q;
    logic [RD_LAT-1:0]   pipe_own_q;
    logic [RD_LAT-1:0]   pipe_lst_q;

    // Combinational helpers
    logic                any_req_s;
    logic                win_s;
    logic [ADDR_W-1:0]   grant_start_s;
    logic [LEN_W-1:0]    grant_len_s;
    logic                gnt_s;
    logic                rd_en_s;
    logic                last_rd_s;
    logic                up_empty_s;
    logic                done_s;

    // Pick the winner: the pointed-to requester if it asks, otherwise the other one
    always_comb begin
        any_req_s = req0 | req1;
        if (rr_q == 1'b1) begin
            win_s = req1 ? 1'b1 : 1'b0;
        end else begin
            win_s = req0 ? 1'b0 : 1'b1;
        end
        if (win_s == 1'b1) begin
            grant_start_s = start1;
            grant_len_s   = len1;
        end else begin
            grant_start_s = start0;
            grant_len_s   = len0;
        end
    end

    // True when every pipeline stage ahead of the output stage is empty
    always_comb begin
        up_empty_s = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            up_empty_s = up_empty_s & ~pipe_vld_q[i];
        end
    end

    // Next-state logic: grant in IDLE, stream addresses in BURST, wait out the pipeline in DRAIN
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        gnt_s       = 1'b0;
        rd_en_s     = 1'b0;
        last_rd_s   = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // No grant is handed out while reset is being applied.
                if (rst && any_req_s) begin
                    gnt_s       = 1'b1;
                    owner_d     = win_s;
                    rr_d        = ~win_s;
                    cur_addr_d  = grant_start_s;
                    remaining_d = grant_len_s;
                    if (grant_len_s != {LEN_W{1'b0}}) begin
                        state_d = S_BURST;
                    end else begin
                        // Zero-length burst: no reads, just the done pulse.
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                rd_en_s     = 1'b1;
                cur_addr_d  = cur_addr_q + ADDR_W'(1);
                remaining_d = remaining_q - LEN_W'(1);
                if (remaining_q == LEN_W'(1)) begin
                    last_rd_s = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    state_d   = S_BURST;
                end
            end
            S_DRAIN: begin
                // Once only the output stage can hold data, the final word
                // (if any) is being presented now, so done goes out with it.
                if (up_empty_s) begin
                    done_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            cur_addr_q  <= {ADDR_W{1'b0}};
            remaining_q <= {LEN_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Valid pipeline: shift an owner/last tag alongside each RAM read
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld_q <= {RD_LAT{1'b0}};
            pipe_own_q <= {RD_LAT{1'b0}};
            pipe_lst_q <= {RD_LAT{1'b0}};
        end else begin
            pipe_vld_q[0] <= rd_en_s;
            pipe_own_q[0] <= owner_q;
            pipe_lst_q[0] <= last_rd_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_own_q[i] <= pipe_own_q[i-1];
                pipe_lst_q[i] <= pipe_lst_q[i-1];
            end
        end
    end

    // Output decode: grants, RAM port, per-requester tags and busy
    always_comb begin
        gnt0      = gnt_s & ~win_s;
        gnt1      = gnt_s & win_s;
        ram_rd_en = rd_en_s;
        if (rd_en_s) begin
            ram_addr = cur_addr_q;
        end else begin
            ram_addr = {ADDR_W{1'b0}};
        end
        valid0 = pipe_vld_q[RD_LAT-1] & ~pipe_own_q[RD_LAT-1];
        valid1 = pipe_vld_q[RD_LAT-1] &  pipe_own_q[RD_LAT-1];
        last0  = pipe_vld_q[RD_LAT-1] & pipe_lst_q[RD_LAT-1] & ~pipe_own_q[RD_LAT-1];
        last1  = pipe_vld_q[RD_LAT-1] & pipe_lst_q[RD_LAT-1] &  pipe_own_q[RD_LAT-1];
        done0  = done_s & ~owner_q;
        done1  = done_s &  owner_q;
        busy   = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_new_patch_rd_arbiter.sv
// Bench for new_patch_rd_arbiter: two instances (RD_LAT=1 and RD_LAT=3) are
// checked every cycle against a schedule-based reference model, plus a table
// of single bursts and hand-written multi-cycle sequences.

module tb_new_patch_rd_arbiter;

    localparam int AW   = 11;
    localparam int LW   = 8;
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    logic rst;

    logic          req0 [2];
    logic [AW-1:0] start0 [2];
    logic [LW-1:0] len0 [2];
    logic          gnt0 [2];
    logic          valid0 [2];
    logic          last0 [2];
    logic          done0 [2];
    logic          req1 [2];
    logic [AW-1:0] start1 [2];
    logic [LW-1:0] len1 [2];
    logic          gnt1 [2];
    logic          valid1 [2];
    logic          last1 [2];
    logic          done1 [2];
    logic          ram_rd_en [2];
    logic [AW-1:0] ram_addr [2];
    logic          busy [2];

    always #5 clk = ~clk;

    new_patch_rd_arbiter #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .start0(start0[0]), .len0(len0[0]),
        .gnt0(gnt0[0]), .valid0(valid0[0]), .last0(last0[0]), .done0(done0[0]),
        .req1(req1[0]), .start1(start1[0]), .len1(len1[0]),
        .gnt1(gnt1[0]), .valid1(valid1[0]), .last1(last1[0]), .done1(done1[0]),
        .ram_rd_en(ram_rd_en[0]), .ram_addr(ram_addr[0]), .busy(busy[0])
    );

    new_patch_rd_arbiter #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .start0(start0[1]), .len0(len0[1]),
        .gnt0(gnt0[1]), .valid0(valid0[1]), .last0(last0[1]), .done0(done0[1]),
        .req1(req1[1]), .start1(start1[1]), .len1(len1[1]),
        .gnt1(gnt1[1]), .valid1(valid1[1]), .last1(last1[1]), .done1(done1[1]),
        .ram_rd_en(ram_rd_en[1]), .ram_addr(ram_addr[1]), .busy(busy[1])
    );

    // Reference model: expected outputs scheduled per absolute cycle
    int            total;
    int            bad;
    int            cyc;
    int            free_at [2];
    bit            rr_m [2];
    bit            sticky [2];
    bit            drop [2][2];
    bit            e_gnt [2][2];
    bit            e_rd [2][NCYC];
    bit [AW-1:0]   e_addr [2][NCYC];
    bit            e_val [2][2][NCYC];
    bit            e_last [2][2][NCYC];
    bit            e_done [2][2][NCYC];
    bit            e_busy [2][NCYC];

    // Observations used by the table rows and hand sequences
    int            o_gnt [2];
    int            o_who [2];
    int            o_done [2];
    int            o_nval [2];
    int            o_nrd [2];
    logic [AW-1:0] o_laddr [2];
    int            g_cyc [$];
    int            g_who [$];

    typedef struct {
        int            k;
        int            who;
        logic [AW-1:0] start;
        logic [LW-1:0] len;
        int            done_ofs;
        int            nvalid;
        logic [AW-1:0] last_addr;
    } vec_t;

    vec_t tbl [6];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [LW-1:0] rand_len();
        if ($urandom_range(0, 4) == 0) return 8'd0;
        if ($urandom_range(0, 49) == 0) return LW'($urandom_range(40, 80));
        return LW'($urandom_range(1, 12));
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic clear_obs(input int k);
        o_gnt[k]   = -1;
        o_who[k]   = -1;
        o_done[k]  = -1;
        o_nval[k]  = 0;
        o_nrd[k]   = 0;
        o_laddr[k] = '0;
    endtask

    // A grant at cycle T of n words from s: reads T+1..T+n, data RD_LAT later
    task automatic schedule(input int k, input int w, input logic [AW-1:0] s, input logic [LW-1:0] n);
        int t;
        int l;
        int ln;
        t  = cyc;
        l  = lat_of(k);
        ln = int'(n);
        e_gnt[k][w] = 1'b1;
        rr_m[k]     = (w == 0);
        if (ln == 0) begin
            e_done[k][w][t+1] = 1'b1;
            e_busy[k][t+1]    = 1'b1;
            free_at[k]        = t + 2;
        end else begin
            for (int i = 0; i < ln; i++) begin
                e_rd[k][t+1+i]      = 1'b1;
                e_addr[k][t+1+i]    = AW'((int'(s) + i) % 2048);
                e_val[k][w][t+1+i+l] = 1'b1;
            end
            e_last[k][w][t+ln+l] = 1'b1;
            e_done[k][w][t+ln+l] = 1'b1;
            for (int c = t + 1; c <= t + ln + l; c++) e_busy[k][c] = 1'b1;
            free_at[k] = t + ln + l + 1;
        end
        if (!sticky[k]) drop[k][w] = 1'b1;
    endtask

    task automatic model_step();
        int w;
        for (int k = 0; k < 2; k++) begin
            e_gnt[k][0] = 1'b0;
            e_gnt[k][1] = 1'b0;
            if (rst === 1'b1 && cyc >= free_at[k] && (req0[k] || req1[k])) begin
                if (rr_m[k]) w = req1[k] ? 1 : 0;
                else         w = req0[k] ? 0 : 1;
                if (w == 0) schedule(k, 0, start0[k], len0[k]);
                else        schedule(k, 1, start1[k], len1[k]);
            end
            if (rst !== 1'b1) begin
                for (int c = cyc + 1; c < cyc + 400 && c < NCYC; c++) begin
                    e_rd[k][c]   = 1'b0;
                    e_addr[k][c] = '0;
                    e_busy[k][c] = 1'b0;
                    for (int o = 0; o < 2; o++) begin
                        e_val[k][o][c]  = 1'b0;
                        e_last[k][o][c] = 1'b0;
                        e_done[k][o][c] = 1'b0;
                    end
                end
                free_at[k] = cyc + 1;
                rr_m[k]    = 1'b0;
            end
        end
    endtask

    // One clock cycle: model, compare mid-cycle, advance, release granted requests
    task automatic tick();
        model_step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("gnt0", k, gnt0[k], e_gnt[k][0]);
            chk("gnt1", k, gnt1[k], e_gnt[k][1]);
            chk("ram_rd_en", k, ram_rd_en[k], e_rd[k][cyc]);
            chk("ram_addr", k, ram_addr[k], e_addr[k][cyc]);
            chk("valid0", k, valid0[k], e_val[k][0][cyc]);
            chk("valid1", k, valid1[k], e_val[k][1][cyc]);
            chk("last0", k, last0[k], e_last[k][0][cyc]);
            chk("last1", k, last1[k], e_last[k][1][cyc]);
            chk("done0", k, done0[k], e_done[k][0][cyc]);
            chk("done1", k, done1[k], e_done[k][1][cyc]);
            chk("busy", k, busy[k], e_busy[k][cyc]);
            chk("gnt_excl", k, gnt0[k] & gnt1[k], 0);
            chk("valid_excl", k, valid0[k] & valid1[k], 0);
            if (gnt0[k] || gnt1[k]) begin
                o_gnt[k] = cyc;
                o_who[k] = int'(gnt1[k]);
                if (k == 0) begin
                    g_cyc.push_back(cyc);
                    g_who.push_back(int'(gnt1[k]));
                end
            end
            if (done0[k] || done1[k]) o_done[k] = cyc;
            if (valid0[k] || valid1[k]) o_nval[k]++;
            if (ram_rd_en[k]) begin
                o_nrd[k]++;
                o_laddr[k] = ram_addr[k];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (drop[k][0]) req0[k] = 1'b0;
            if (drop[k][1]) req1[k] = 1'b0;
            drop[k][0] = 1'b0;
            drop[k][1] = 1'b0;
        end
    endtask

    initial begin
        int k;
        int t0;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 1'b0; start0[i] = '0; len0[i] = '0;
            req1[i] = 1'b0; start1[i] = '0; len1[i] = '0;
            free_at[i] = 0; rr_m[i] = 1'b0; sticky[i] = 1'b0;
            drop[i][0] = 1'b0; drop[i][1] = 1'b0;
            clear_obs(i);
        end

        //             k  who start     len    done nval last_addr
        tbl[0] = '{0, 0, 11'h010, 8'd4,   5,   4,   11'h013};
        tbl[1] = '{0, 1, 11'h7FE, 8'd4,   5,   4,   11'h001};
        tbl[2] = '{0, 0, 11'h123, 8'd0,   1,   0,   11'h000};
        tbl[3] = '{1, 1, 11'h200, 8'd3,   6,   3,   11'h202};
        tbl[4] = '{0, 0, 11'h700, 8'd255, 256, 255, 11'h7FE};
        tbl[5] = '{1, 0, 11'h7FF, 8'd1,   4,   1,   11'h7FF};

        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b1;

        // Table of single bursts on an idle arbiter
        for (int r = 0; r < 6; r++) begin
            k = tbl[r].k;
            clear_obs(k);
            t0 = cyc;
            if (tbl[r].who == 0) begin
                start0[k] = tbl[r].start; len0[k] = tbl[r].len; req0[k] = 1'b1;
            end else begin
                start1[k] = tbl[r].start; len1[k] = tbl[r].len; req1[k] = 1'b1;
            end
            repeat (int'(tbl[r].len) + 8) tick();
            chk("row_gnt_ofs", k, o_gnt[k] - t0, 0);
            chk("row_who", k, o_who[k], tbl[r].who);
            chk("row_done_ofs", k, o_done[k] - t0, tbl[r].done_ofs);
            chk("row_nvalid", k, o_nval[k], tbl[r].nvalid);
            chk("row_nrd", k, o_nrd[k], 32'(tbl[r].len));
            chk("row_last_addr", k, o_laddr[k], 32'(tbl[r].last_addr));
        end

        // Both requesters held high: grants alternate 0,1,0,1 every 4 cycles
        rst = 1'b0;
        tick();
        rst = 1'b1;
        g_cyc.delete();
        g_who.delete();
        sticky[0] = 1'b1;
        start0[0] = 11'h040; len0[0] = 8'd2;
        start1[0] = 11'h050; len1[0] = 8'd2;
        req0[0] = 1'b1; req1[0] = 1'b1;
        t0 = cyc;
        repeat (16) tick();
        req0[0] = 1'b0; req1[0] = 1'b0; sticky[0] = 1'b0;
        repeat (8) tick();
        chk("alt_count", 0, g_cyc.size(), 4);
        for (int i = 0; i < 4 && i < g_cyc.size(); i++) begin
            chk("alt_cyc", 0, g_cyc[i] - t0, 4 * i);
            chk("alt_who", 0, g_who[i], i % 2);
        end

        // Reset during the 3rd read of an 8-read burst abandons it
        clear_obs(0);
        start0[0] = 11'h100; len0[0] = 8'd8; req0[0] = 1'b1;
        t0 = cyc;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (12) tick();
        chk("rst_last_addr", 0, o_laddr[0], 11'h102);
        chk("rst_nrd", 0, o_nrd[0], 3);
        chk("rst_no_done", 0, o_done[0], -1);

        // After reset the pointer is back at requester 0
        g_cyc.delete();
        g_who.delete();
        start0[0] = 11'h300; len0[0] = 8'd1;
        start1[0] = 11'h310; len1[0] = 8'd1;
        req0[0] = 1'b1; req1[0] = 1'b1;
        t0 = cyc;
        repeat (10) tick();
        chk("post_rst_ngnt", 0, g_cyc.size(), 2);
        if (g_cyc.size() >= 2) begin
            chk("post_rst_who0", 0, g_who[0], 0);
            chk("post_rst_cyc0", 0, g_cyc[0] - t0, 0);
            chk("post_rst_who1", 0, g_who[1], 1);
            chk("post_rst_cyc1", 0, g_cyc[1] - t0, 3);
        end

        // Lone requester 1 after reset is granted immediately
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_obs(0);
        start1[0] = 11'h020; len1[0] = 8'd2; req1[0] = 1'b1;
        t0 = cyc;
        repeat (8) tick();
        chk("lone1_gnt", 0, o_gnt[0] - t0, 0);
        chk("lone1_who", 0, o_who[0], 1);
        chk("lone1_done", 0, o_done[0] - t0, 3);

        // Randomized traffic on both instances with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            for (int j = 0; j < 2; j++) begin
                if (!req0[j] && $urandom_range(0, 3) == 0) begin
                    start0[j] = AW'($urandom);
                    len0[j]   = rand_len();
                    req0[j]   = 1'b1;
                end
                if (!req1[j] && $urandom_range(0, 3) == 0) begin
                    start1[j] = AW'($urandom);
                    len1[j]   = rand_len();
                    req1[j]   = 1'b1;
                end
            end
            tick();
        end
        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            req0[j] = 1'b0;
            req1[j] = 1'b0;
        end
        repeat (100) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
